// File: rtl/prv664_dispatch_sched.sv
// In-order read scheduler for the two decode queues: pops up to two micro-ops per cycle
// in program order and serialises exclusive micro-ops against everything in flight.
module prv664_dispatch_sched #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned MAX_INFLIGHT = 32,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              flush_i,
  input  logic              q0_valid_i,
  input  logic [DATA_W-1:0] q0_data_i,
  input  logic              q0_excl_i,
  output logic              q0_pop_o,
  input  logic              q1_valid_i,
  input  logic [DATA_W-1:0] q1_data_i,
  input  logic              q1_excl_i,
  output logic              q1_pop_o,
  output logic              iss0_valid_o,
  output logic [DATA_W-1:0] iss0_data_o,
  output logic              iss1_valid_o,
  output logic [DATA_W-1:0] iss1_data_o,
  input  logic              iss_ready_i,
  input  logic [1:0]        retire_cnt_i,
  output logic [CNT_W-1:0]  inflight_o,
  output logic              rdptr_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_EXCL_WAIT = 2'd1,
    ST_EXCL_BUSY = 2'd2
  } state_e;

  localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_INFLIGHT);

  state_e             state_q, state_d;
  logic               rdptr_q, rdptr_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic               old_valid, old_excl, yng_valid, yng_excl;
  logic [DATA_W-1:0]  old_data, yng_data;
  logic [CNT_W:0]     inflight_ext, avail_ext;
  logic               room1, room2, drained;
  logic               slot0, slot1, fire, fire1;
  logic [1:0]         n_iss;

  // Older op always sits at the queue the read pointer names.
  assign old_valid = rdptr_q ? q1_valid_i : q0_valid_i;
  assign old_excl  = rdptr_q ? q1_excl_i  : q0_excl_i;
  assign old_data  = rdptr_q ? q1_data_i  : q0_data_i;
  assign yng_valid = rdptr_q ? q0_valid_i : q1_valid_i;
  assign yng_excl  = rdptr_q ? q0_excl_i  : q1_excl_i;
  assign yng_data  = rdptr_q ? q0_data_i  : q1_data_i;

  // Room is judged on the registered count only; same-cycle retires do not help.
  assign inflight_ext = {1'b0, inflight_q};
  assign room1        = (inflight_ext + (CNT_W + 1)'(1)) <= MAX_EXT;
  assign room2        = (inflight_ext + (CNT_W + 1)'(2)) <= MAX_EXT;
  assign drained      = (inflight_q == '0);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    slot0   = 1'b0;
    slot1   = 1'b0;
    state_d = state_q;

    unique case (state_q)
      ST_RUN: begin
        if (old_valid && old_excl) begin
          slot0 = drained;
          if (!drained) state_d = ST_EXCL_WAIT;
        end else begin
          slot0 = old_valid && room1;
          slot1 = slot0 && yng_valid && !yng_excl && room2;
        end
      end
      ST_EXCL_WAIT: slot0 = old_valid && drained;
      ST_EXCL_BUSY: if (drained) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase

    if (flush_i || arst_i) begin
      slot0 = 1'b0;
      slot1 = 1'b0;
    end

    fire  = iss_ready_i && slot0;
    fire1 = fire && slot1;
    n_iss = {1'b0, fire} + {1'b0, fire1};

    if (fire && (state_q == ST_EXCL_WAIT || old_excl)) state_d = ST_EXCL_BUSY;

    rdptr_d    = rdptr_q ^ n_iss[0];
    inflight_d = inflight_q + CNT_W'(n_iss) - CNT_W'(retire_cnt_i);

    if (flush_i) begin
      state_d    = ST_RUN;
      rdptr_d    = 1'b0;
      inflight_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_RUN;
      rdptr_q    <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      rdptr_q    <= rdptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign iss0_valid_o = slot0;
  assign iss1_valid_o = slot1;
  assign iss0_data_o  = old_data;
  assign iss1_data_o  = yng_data;
  assign q0_pop_o     = rdptr_q ? fire1 : fire;
  assign q1_pop_o     = rdptr_q ? fire  : fire1;
  assign inflight_o   = inflight_q;
  assign rdptr_o      = rdptr_q;
  assign state_o      = state_q;

  // Retiring more than is in flight means the backend lost track of its ops.
  assign avail_ext = inflight_ext + (CNT_W + 1)'(n_iss);
  retire_in_range_a: assert property (@(posedge clk_i) disable iff (arst_i || flush_i)
    (CNT_W + 1)'(retire_cnt_i) <= avail_ext);

endmodule

// File: doc/prv664_dispatch_sched.md
# prv664_dispatch_sched

In-order read scheduler for the two decode queues that sit behind the decode stage. Each cycle it pops up to two micro-ops from the queue heads in program order, using a 1-bit read pointer that mirrors the decode-side 0-1-0-1 write order. It presents the micro-ops as an issue group to dispatch. It also serialises exclusive micro-ops (AMO/SYSTEM/MISC-MEM) against everything in flight, using an in-flight counter and a 3-state FSM.

## Interface
Parameters:
- DATA_W, 128, micro-op payload width carried from queue to issue port.
- MAX_INFLIGHT, 32, maximum issued-but-not-retired micro-ops.
- CNT_W, $clog2(MAX_INFLIGHT+1), in-flight counter width (derived).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  pipeline flush; synchronous.
- q0_valid_i  in  1  decode queue 0 head valid.
- q0_data_i  in  DATA_W  queue 0 head payload.
- q0_excl_i  in  1  queue 0 head is exclusive.
- q0_pop_o  out  1  pop queue 0 head this cycle.
- q1_valid_i, q1_data_i, q1_excl_i, q1_pop_o  same as queue 0, for queue 1.
- iss0_valid_o  out  1  issue slot 0 (older op) valid.
- iss0_data_o  out  DATA_W  slot 0 payload.
- iss1_valid_o  out  1  issue slot 1 (younger op) valid.
- iss1_data_o  out  DATA_W  slot 1 payload.
- iss_ready_i  in  1  dispatch accepts every valid slot this cycle (group handshake).
- retire_cnt_i  in  2  micro-ops retired this cycle, 0..2.
- inflight_o  out  CNT_W  registered in-flight count.
- rdptr_o  out  1  registered read pointer.
- state_o  out  2  FSM state: RUN=0, EXCL_WAIT=1, EXCL_BUSY=2.

## Operation
- Head selection:
  - Older op = queue[rdptr]; younger op = queue[~rdptr].
  - Older op maps to slot 0; younger op maps to slot 1.
- Issue availability: fire = iss_ready_i & iss0_valid_o; n_iss = fire + (fire & iss1_valid_o).
- Slot 0 valid in RUN:
  - Older op non-exclusive: older valid and inflight+1 ≤ MAX_INFLIGHT.
  - Older op exclusive: older valid and inflight==0.
- Slot 1 valid: state RUN, slot 0 valid, both ops non-exclusive, younger valid, and inflight+2 ≤ MAX_INFLIGHT. Slot 1 is never valid without slot 0.
- Pops:
  - q[rdptr] pops when slot 0 fires.
  - q[~rdptr] pops when slot 1 fires.
  - Pops are combinational.
- rdptr update: rdptr ^= n_iss[0]. One op toggles the pointer; two ops leave it unchanged.
- Counter update: inflight ← inflight + n_iss − retire_cnt_i.
  - Retiring more than inflight+n_iss is a protocol error; simulation-only assertion.
- FSM:
  - RUN, exclusive older op, inflight≠0: no issue; → EXCL_WAIT.
  - RUN, exclusive older op, inflight==0: slot 0 valid alone; on fire → EXCL_BUSY.
  - EXCL_WAIT: slot 0 valid only when registered inflight==0; on fire → EXCL_BUSY. Slot 1 is never valid.
  - EXCL_BUSY: no issue. When registered inflight==0, → RUN. First issue is in the following cycle.
- Flush:
  - All valids and pops are forced 0 in the flush cycle.
  - Next cycle: rdptr=0, inflight=0, state=RUN. retire_cnt_i is ignored in the flush cycle.
- Data outputs are combinational muxes of the queue heads. Outputs are don't-care when the matching valid is low.

## Timing
- Reset values: rdptr_o=0, inflight_o=0, state_o=RUN. All valid and pop outputs are 0 while arst_i is high.
- Latency: zero-cycle queue head → issue (combinational). State updates on the next clk_i edge.
- Issue stall: slots are held stable while iss_ready_i=0; no pop occurs.
- An exclusive op waits at least one cycle after the last retire before issuing, because it uses registered inflight.
- The op after an exclusive op issues no earlier than 1 cycle after the exclusive op's retire cycle. Sequence: retire makes inflight 0 → state goes to RUN → issue on the next cycle.
- MAX_INFLIGHT boundaries:
  - inflight==MAX−1: only slot 0 may issue.
  - inflight==MAX: no issue.
  - Retire and issue in the same cycle are both counted; room is computed on registered inflight only.
- Mid-operation reset: returns immediately to reset values. Queue contents are not the block's concern.

## Test plan
- Ordering: rdptr=0; q0 holds A, q1 holds B, both non-exclusive; ready=1. Required: iss0=A, iss1=B, both queues pop, rdptr stays 0, inflight 0→2.
- Pointer toggle: only q0 valid (C); ready=1. Required: iss0=C, rdptr→1. Next cycle q1 holds D and q0 holds E: iss0=D, iss1=E, both pop.
- Exclusive drain: inflight=3; older op exclusive. Required: state→EXCL_WAIT, no issue. retire 2,1: inflight→0. Next cycle iss0 valid alone; on fire state→EXCL_BUSY, inflight=1. Retire 1: inflight→0, state→RUN, then the younger op issues the following cycle.
- Younger exclusive: older non-exclusive, younger exclusive, inflight=0, ready=1. Required: only slot 0 issues; the exclusive op becomes older next cycle and issues alone.
- Credit limit: MAX_INFLIGHT=4, inflight=3, both heads valid. Required: only iss0 valid. With same-cycle retire_cnt_i=2 still only one issues; inflight→2.
- Flush: in EXCL_BUSY with rdptr=1 and inflight=2, assert flush_i. Required: no valids or pops that cycle; next cycle state=RUN, rdptr=0, inflight=0.
